// File: rtl/ysyx_rnu_rou_queue_pkg.sv
// Shared rename-to-reorder definitions: top-level lane/depth values and the
// packed micro-op payload so RNU and ROU pack entries identically.
package ysyx_rnu_rou_queue_pkg;

  localparam int YSYX_RN_LANES   = 2;
  localparam int YSYX_DISP_LANES = 2;
  localparam int YSYX_RNQ_DEPTH  = 8;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [6:0]  prd;
    logic [6:0]  prs1;
    logic [6:0]  prs2;
    logic [6:0]  old_prd;
    logic [3:0]  fu_type;
  } rnu_rou_uop_t;

  localparam int RNU_ROU_W = $bits(rnu_rou_uop_t);

endpackage

// File: rtl/ysyx_mlane_ram.sv
// DEPTH x W storage with LANES_IN write ports and LANES_OUT combinational
// read ports; all addresses arrive already reduced modulo DEPTH.
module ysyx_mlane_ram #(
  parameter int W         = 128,
  parameter int DEPTH     = 8,
  parameter int LANES_IN  = 2,
  parameter int LANES_OUT = 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic [LANES_IN-1:0]     we,
  input  logic [LANES_IN*AW-1:0]  waddr,
  input  logic [LANES_IN*W-1:0]   wdata,
  input  logic [LANES_OUT*AW-1:0] raddr,
  output logic [LANES_OUT*W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Array is intentionally not reset; validity is tracked by the pointers.
  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES_IN; i++) begin
      if (we[i]) mem[waddr[i*AW +: AW]] <= wdata[i*W +: W];
    end
  end

  for (genvar r = 0; r < LANES_OUT; r++) begin : g_rd
    assign rdata[r*W +: W] = mem[raddr[r*AW +: AW]];
  end

endmodule

// File: rtl/ysyx_rnu_rou_queue.sv
// Multi-lane in-order queue between rename and reorder: up to LANES_IN pushes
// and LANES_OUT pops per cycle, single-cycle flush, no bypass.
module ysyx_rnu_rou_queue
  import ysyx_rnu_rou_queue_pkg::*;
#(
  parameter int W         = RNU_ROU_W,
  parameter int DEPTH     = YSYX_RNQ_DEPTH,
  parameter int LANES_IN  = YSYX_RN_LANES,
  parameter int LANES_OUT = YSYX_DISP_LANES,
  localparam int AW       = $clog2(DEPTH),
  localparam int PW       = AW + 1,
  localparam int OW       = $clog2(LANES_OUT + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [LANES_IN-1:0]    in_valid,
  input  logic [LANES_IN*W-1:0]  in_data,
  output logic                   in_ready,
  output logic [LANES_OUT-1:0]   out_valid,
  output logic [LANES_OUT*W-1:0] out_data,
  input  logic [OW-1:0]          out_pop,
  output logic [PW-1:0]          count,
  output logic                   empty,
  output logic                   full
);

  logic [PW-1:0]          head, tail, cnt;
  logic [PW-1:0]          n_push, n_acc, n_pop;
  logic                   push_fire;
  logic [LANES_IN-1:0]    we;
  logic [LANES_IN*AW-1:0] waddr;
  logic [LANES_OUT*AW-1:0] raddr;

  always_comb begin
    n_push = '0;
    for (int i = 0; i < LANES_IN; i++) n_push = n_push + PW'(in_valid[i]);
  end

  // Ready looks only at the registered count, so no input reaches it.
  assign in_ready  = (cnt <= PW'(DEPTH - LANES_IN));
  assign push_fire = in_ready & in_valid[0] & ~flush;
  assign n_acc     = push_fire ? n_push : '0;
  assign n_pop     = PW'(out_pop);

  for (genvar i = 0; i < LANES_IN; i++) begin : g_wr
    assign we[i]               = push_fire & in_valid[i];
    assign waddr[i*AW +: AW]   = tail[AW-1:0] + AW'(i);
  end

  for (genvar i = 0; i < LANES_OUT; i++) begin : g_rd
    assign raddr[i*AW +: AW] = head[AW-1:0] + AW'(i);
    assign out_valid[i]      = (PW'(i) < cnt);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + n_pop;
      tail <= tail + n_acc;
      cnt  <= cnt + n_acc - n_pop;
    end
  end

  ysyx_mlane_ram #(
    .W         (W),
    .DEPTH     (DEPTH),
    .LANES_IN  (LANES_IN),
    .LANES_OUT (LANES_OUT)
  ) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (waddr),
    .wdata (in_data),
    .raddr (raddr),
    .rdata (out_data)
  );

  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == PW'(DEPTH));

  // Protocol checks; the counter must always match the pointer distance.
  always_ff @(posedge clock) begin
    assert (cnt == PW'(tail - head));
    if (!flush) begin
      assert ((in_valid & (in_valid + 1'b1)) == '0);
      assert (n_pop <= PW'(LANES_OUT) && n_pop <= cnt);
    end
  end

endmodule

// File: doc/ysyx_rnu_rou_queue.md
# ysyx_rnu_rou_queue

Parametrised multi-lane in-order queue between the rename unit (RNU) and the reorder unit (ROU). It carries packed rename-to-reorder micro-op payloads and lets RNU push up to `LANES_IN` and ROU pop up to `LANES_OUT` entries per cycle. It also supports a single-cycle pipeline flush. It replaces the single-entry valid/ready hop on the rename-to-reorder path and decouples rename width from dispatch width.

## Interface
Parameters:
- `W`, 128: payload width per entry (packed rename-to-reorder micro-op fields; packing done by caller).
- `DEPTH`, 8: entries; power of two, `DEPTH >= LANES_IN`, `DEPTH >= LANES_OUT`.
- `LANES_IN`, 2: max pushes per cycle.
- `LANES_OUT`, 2: max pops per cycle.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  discard all contents and any same-cycle push.
- `in_valid`  in  `LANES_IN`  per-lane push request; must be a prefix (lane i valid implies lanes 0..i-1 valid).
- `in_data`  in  `LANES_IN*W`  lane i at bits `[i*W +: W]`; lane 0 is oldest.
- `in_ready`  out  1  group accept: all valid lanes accepted this cycle when high.
- `out_valid`  out  `LANES_OUT`  prefix mask of oldest stored entries.
- `out_data`  out  `LANES_OUT*W`  lane 0 = head entry.
- `out_pop`  in  `$clog2(LANES_OUT+1)`  number of entries consumed this cycle; must be `<= popcount(out_valid)`.
- `count`  out  `$clog2(DEPTH)+1`  occupied entries.
- `empty`, `full`  out  1  `count==0`, `count==DEPTH`.

## Operation
- Storage: circular array, `head`/`tail` pointers each `$clog2(DEPTH)+1` bits. The MSB is the wrap bit. Index is the low bits, mod DEPTH.
- `in_ready = (DEPTH - count) >= LANES_IN`. It depends on registered `count` only and never on `out_pop` or `flush`. This leaves no combinational path.
- Push: when `in_ready && in_valid[0]`, write `n_in = popcount(in_valid)` lanes to `tail..tail+n_in-1` and advance `tail += n_in`.
- Pop: `head += out_pop`. Popped entries are not cleared.
- `count_next = count + n_in_accepted - out_pop`. A simultaneous push and pop is legal in any combination.
- `out_valid[i] = (i < count)`. `out_data` lane i = `mem[(head+i) mod DEPTH]`. Data on invalid lanes is unspecified.
- Flush: `head`, `tail` and `count` go to 0 next cycle. A same-cycle push and pop are ignored. Flush has priority over everything.
- Protocol violations (non-prefix `in_valid`, `out_pop` exceeding valid entries) are undefined. They are caught by assertions, not handled.
- There is no bypass. An entry pushed in cycle N is first visible on `out_*` in cycle N+1.

## Timing
- Reset (async assert, sync-released by the system): `head=tail=count=0`, `out_valid=0`, `empty=1`, `full=0`, `in_ready=1`. The array is not reset.
- Push-to-out latency is 1 cycle. Pop-to-free latency is 1 cycle, so `in_ready` rises the cycle after the pop that frees space.
- A full queue accepts no push even if a pop happens the same cycle.
- Pointer wrap: the low bits wrap mod DEPTH. The wrap bit toggles. `count` is the registered counter, not a pointer difference, but the two must agree (assertion).
- Reset asserted mid-operation: all state clears immediately, and outputs show reset values within the same cycle.

## Structure
- Add to `ysyx.svh`: `YSYX_RN_LANES`, `YSYX_DISP_LANES` and `YSYX_RNQ_DEPTH`, which are the top-level parameter values.
- A packed typedef of the rename-to-reorder payload, with `W = $bits(...)`, lives in the shared package so both sides pack identically.
- One sub-module, `ysyx_mlane_ram`: `DEPTH x W` array with `LANES_IN` write ports and `LANES_OUT` combinational read ports. Its addresses are pre-computed modulo DEPTH.
- The top module holds the pointers, counter, ready/valid logic and assertions.

## Test plan
The bench uses `DEPTH=8`, `LANES_IN=2`, `LANES_OUT=2`.
- Reset mid-run at `count=5`, `reset` low for 1 cycle -> same cycle `count=0`, `out_valid=2'b00`, `in_ready=1`. The following pushes start at index 0.
- Four pushes of `in_valid=2'b11` (values 1..8), no pops -> `count=8`, `full=1`, `in_ready=0`. `out_data` lanes show 1 and 2.
- Partial push `in_valid=2'b01` (value 9) when `count=6` -> `count=7`. Next cycle `in_ready=0` (only 1 free).
- At `count=6`, push 2 with `out_pop=1` -> `count=7`. The head advances by 1 and the order is preserved.
- Stream 40 sequential values with random legal push/pop widths -> output order matches input exactly across at least 4 pointer wraps.
- `flush` with `in_valid=2'b11` and `out_pop=2` in the same cycle at `count=4` -> next cycle `count=0`, `empty=1`. The flushed and pushed values never appear.
